id_ex_stage: RTL and testbench

- Pipeline register between decode (register unit read ports, immediate generator, control decoder) and execute in the segmented RV32I core.
- Captures the decoded instruction plus the rs1/rs2 read data produced by the register unit.
- Detects load-use hazards, stalls IF/ID and inserts bubbles.
- Also inserts bubbles on branch flush and keeps saturating stall/flush event counters for debug.

---
 rtl/core_pkg.sv | 24 ++
 rtl/sat_counter.sv | 20 ++
 rtl/id_ex_stage.sv | 111 +++++++++++
 tb/tb_id_ex_stage.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types for the segmented RV32I core.
// ID/EX bundle layout and the bubble constant.
package core_pkg;

  localparam int REG_IDX_W = 5;
  localparam int XLEN      = 32;

  // Control width is chosen per instance, so ctrl is held beside this bundle.
  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      pc;
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      rs1_data;
    logic [XLEN-1:0]      rs2_data;
    logic [XLEN-1:0]      imm;
    logic                 mem_rd;
    logic                 ru_wr;
  } ex_bundle_t;

  localparam ex_bundle_t BUBBLE = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for debug events.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // count events, stick at the maximum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (inc && (cnt != '1))
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall.
// Bubbles on flush or hazard; counts both events.
module id_ex_stage
  import core_pkg::*;
#(
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 id_valid,
  input  logic [XLEN-1:0]      id_pc,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic [REG_IDX_W-1:0] id_rd,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic [XLEN-1:0]      id_rs1_data,
  input  logic [XLEN-1:0]      id_rs2_data,
  input  logic [XLEN-1:0]      id_imm,
  input  logic [CTRL_W-1:0]    id_ctrl,
  input  logic                 id_mem_rd,
  input  logic                 id_ru_wr,
  output logic                 stall,
  output logic                 ex_valid,
  output logic [XLEN-1:0]      ex_pc,
  output logic [XLEN-1:0]      ex_rs1_data,
  output logic [XLEN-1:0]      ex_rs2_data,
  output logic [XLEN-1:0]      ex_imm,
  output logic [REG_IDX_W-1:0] ex_rs1,
  output logic [REG_IDX_W-1:0] ex_rs2,
  output logic [REG_IDX_W-1:0] ex_rd,
  output logic [CTRL_W-1:0]    ex_ctrl,
  output logic                 ex_mem_rd,
  output logic                 ex_ru_wr,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  ex_bundle_t        q, d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              hazard;
  logic              rs1_hit, rs2_hit;

  // load in EX feeding a source of the ID instruction
  always_comb begin
    rs1_hit = id_uses_rs1 && (id_rs1 == q.rd);
    rs2_hit = id_uses_rs2 && (id_rs2 == q.rd);
    hazard  = q.valid && q.mem_rd && (q.rd != '0)
              && id_valid && (rs1_hit || rs2_hit);
    stall   = hazard && !flush;
  end

  // next EX contents: bubble on flush/hazard, else capture ID
  always_comb begin
    d      = BUBBLE;
    ctrl_d = '0;
    if (!flush && !hazard) begin
      d.valid    = id_valid;
      d.pc       = id_pc;
      d.rs1      = id_rs1;
      d.rs2      = id_rs2;
      d.rd       = id_rd;
      d.rs1_data = id_rs1_data;
      d.rs2_data = id_rs2_data;
      d.imm      = id_imm;
      d.mem_rd   = id_mem_rd && id_valid;
      d.ru_wr    = id_ru_wr && id_valid;
      ctrl_d     = id_ctrl;
    end
  end

  // pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q      <= BUBBLE;
      ctrl_q <= '0;
    end else begin
      q      <= d;
      ctrl_q <= ctrl_d;
    end
  end

  assign ex_valid    = q.valid;
  assign ex_pc       = q.pc;
  assign ex_rs1      = q.rs1;
  assign ex_rs2      = q.rs2;
  assign ex_rd       = q.rd;
  assign ex_rs1_data = q.rs1_data;
  assign ex_rs2_data = q.rs2_data;
  assign ex_imm      = q.imm;
  assign ex_mem_rd   = q.mem_rd;
  assign ex_ru_wr    = q.ru_wr;
  assign ex_ctrl     = ctrl_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush && id_valid),
    .cnt   (flush_cnt)
  );

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage.
// Small counters so saturation is reachable.
module tb_id_ex_stage;

  localparam int CTRL_W = 16;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              id_valid;
  logic [31:0]       id_pc;
  logic [4:0]        id_rs1, id_rs2, id_rd;
  logic              id_uses_rs1, id_uses_rs2;
  logic [31:0]       id_rs1_data, id_rs2_data, id_imm;
  logic [CTRL_W-1:0] id_ctrl;
  logic              id_mem_rd, id_ru_wr;
  logic              stall, ex_valid;
  logic [31:0]       ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]        ex_rs1, ex_rs2, ex_rd;
  logic [CTRL_W-1:0] ex_ctrl;
  logic              ex_mem_rd, ex_ru_wr;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  int npass = 0;
  int ntot  = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .id_valid    (id_valid),
    .id_pc       (id_pc),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rd       (id_rd),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .id_rs1_data (id_rs1_data),
    .id_rs2_data (id_rs2_data),
    .id_imm      (id_imm),
    .id_ctrl     (id_ctrl),
    .id_mem_rd   (id_mem_rd),
    .id_ru_wr    (id_ru_wr),
    .stall       (stall),
    .ex_valid    (ex_valid),
    .ex_pc       (ex_pc),
    .ex_rs1_data (ex_rs1_data),
    .ex_rs2_data (ex_rs2_data),
    .ex_imm      (ex_imm),
    .ex_rs1      (ex_rs1),
    .ex_rs2      (ex_rs2),
    .ex_rd       (ex_rd),
    .ex_ctrl     (ex_ctrl),
    .ex_mem_rd   (ex_mem_rd),
    .ex_ru_wr    (ex_ru_wr),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic ins(input logic v, input logic [31:0] pc,
                     input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rd, input logic u1, input logic u2,
                     input logic mr, input logic wr);
    id_valid    = v;
    id_pc       = pc;
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_rd       = rd;
    id_uses_rs1 = u1;
    id_uses_rs2 = u2;
    id_mem_rd   = mr;
    id_ru_wr    = wr;
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    flush       = 1'b0;
    id_rs1_data = $urandom;
    id_rs2_data = $urandom;
    id_imm      = $urandom;
    id_ctrl     = CTRL_W'($urandom);
    ins(1'b1, 32'h100, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    #12;
    rst_n = 1'b1;
    edge1();

    // flush with a valid ID instruction counts and bubbles
    flush = 1'b1;
    edge1();
    chk("flush_bubble_valid", 32'(ex_valid), 32'd0);
    chk("flush_cnt_1", 32'(flush_cnt), 32'd1);
    flush = 1'b0;
    ins(1'b1, 32'h104, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    edge1();
    chk("pre_reset_pc", ex_pc, 32'h104);

    // asynchronous reset mid-cycle
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(ex_valid), 32'd0);
    chk("rst_pc", ex_pc, 32'd0);
    chk("rst_ctrl", 32'(ex_ctrl), 32'd0);
    chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    #1;
    rst_n = 1'b1;
    edge1();

    // load-use: lw x5 then add x6,x5,x7
    ins(1'b1, 32'h200, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1);
    edge1();
    chk("lw_mem_rd", 32'(ex_mem_rd), 32'd1);
    chk("lw_rd", 32'(ex_rd), 32'd5);
    ins(1'b1, 32'h204, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("lu_stall", 32'(stall), 32'd1);
    edge1();
    chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
    chk("lu_bubble_ru_wr", 32'(ex_ru_wr), 32'd0);
    chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    chk("lu_stall_drop", 32'(stall), 32'd0);
    edge1();
    chk("lu_adv_valid", 32'(ex_valid), 32'd1);
    chk("lu_adv_pc", ex_pc, 32'h204);
    chk("lu_adv_rd", 32'(ex_rd), 32'd6);

    // load to x0 never stalls
    ins(1'b1, 32'h300, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    edge1();
    ins(1'b1, 32'h304, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("x0_stall", 32'(stall), 32'd0);
    edge1();
    chk("x0_adv_pc", ex_pc, 32'h304);

    // rs2 matches but is not read
    ins(1'b1, 32'h400, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b1);
    edge1();
    ins(1'b1, 32'h404, 5'd1, 5'd9, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("rs2_unused_stall", 32'(stall), 32'd0);
    edge1();
    chk("rs2_unused_pc", ex_pc, 32'h404);
    chk("rs2_unused_scnt", 32'(stall_cnt), 32'd1);

    // rs2-only hazard does stall
    ins(1'b1, 32'h410, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b1);
    edge1();
    ins(1'b1, 32'h414, 5'd1, 5'd9, 5'd6, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("rs2_hit_stall", 32'(stall), 32'd1);
    edge1();
    chk("rs2_hit_scnt", 32'(stall_cnt), 32'd2);
    edge1();

    // flush beats hazard
    ins(1'b1, 32'h500, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1);
    edge1();
    ins(1'b1, 32'h504, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);
    flush = 1'b1;
    #1;
    chk("fh_stall", 32'(stall), 32'd0);
    edge1();
    chk("fh_valid", 32'(ex_valid), 32'd0);
    chk("fh_pc", ex_pc, 32'd0);
    chk("fh_flush_cnt", 32'(flush_cnt), 32'd1);
    chk("fh_stall_cnt", 32'(stall_cnt), 32'd2);

    // flush of an empty slot is not counted
    ins(1'b0, 32'h508, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    edge1();
    chk("flush_empty_cnt", 32'(flush_cnt), 32'd1);
    flush = 1'b0;

    // pass-through of a valid instruction
    id_imm      = 32'hFFFF_FFFC;
    id_ctrl     = 16'hA5A5;
    id_rs1_data = 32'h1234_5678;
    id_rs2_data = 32'h9ABC_DEF0;
    ins(1'b1, 32'h40, 5'd2, 5'd3, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1);
    edge1();
    chk("pt_valid", 32'(ex_valid), 32'd1);
    chk("pt_pc", ex_pc, 32'h40);
    chk("pt_imm", ex_imm, 32'hFFFF_FFFC);
    chk("pt_ctrl", 32'(ex_ctrl), 32'hA5A5);
    chk("pt_ru_wr", 32'(ex_ru_wr), 32'd1);
    chk("pt_rs1_data", ex_rs1_data, 32'h1234_5678);
    chk("pt_rs2_data", ex_rs2_data, 32'h9ABC_DEF0);
    chk("pt_rs1", 32'(ex_rs1), 32'd2);
    chk("pt_rs2", 32'(ex_rs2), 32'd3);

    // invalid ID slot: captured but side-effect free
    ins(1'b0, 32'h60, 5'd0, 5'd0, 5'd4, 1'b0, 1'b0, 1'b1, 1'b1);
    edge1();
    chk("inv_valid", 32'(ex_valid), 32'd0);
    chk("inv_pc", ex_pc, 32'h60);
    chk("inv_mem_rd", 32'(ex_mem_rd), 32'd0);
    chk("inv_ru_wr", 32'(ex_ru_wr), 32'd0);

    // repeated load-use pairs drive stall_cnt into saturation
    for (int i = 0; i < 20; i++) begin
      ins(1'b1, 32'h700, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1);
      edge1();
      ins(1'b1, 32'h704, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1);
      edge1();
      if (i == 12)
        chk("sat_reach", 32'(stall_cnt), 32'd15);
    end
    chk("sat_hold", 32'(stall_cnt), 32'd15);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
